// File: rtl/tag_array_pkg.sv
// Shared types and helpers for the N-way tag array.
//   op_e    : request opcodes carried on req_op
//   state_e : control FSM states
//   clog2 / wwidth : width helpers for way indices
package tag_array_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_FILL   = 2'd1,
    OP_INVAL  = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Way-index width; a direct-mapped array still carries a 1-bit way field.
  function automatic int unsigned wwidth(input int unsigned ways);
    return (clog2(ways) < 1) ? 1 : clog2(ways);
  endfunction

endpackage

// File: rtl/tag_way_ram.sv
// Single-port synchronous-read RAM holding one way of the tag array.
//   clock : rising-edge clock
//   we    : write enable, mem[addr] <= wdata at the edge
//   addr  : read/write address; read address is registered
//   wdata : write data {valid, tag}
//   rdata : data at the address registered on the previous edge
module tag_way_ram #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 17
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] addr_q;

  // Storage array has no reset; the owner clears it with a sweep.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    addr_q <= addr;
  end

  assign rdata = mem[addr_q];

endmodule

// File: rtl/tag_array_nway.sv
// N-way cache tag array: per-set valid bits, parallel tag compare,
// invalid-first then round-robin victim selection, sweep-cleared storage.
//   clock, reset_n          : clock, async active-low reset
//   req_valid/req_ready     : command handshake
//   req_op/req_index/req_tag: command, set index, tag
//   rsp_valid               : one-cycle response pulse
//   rsp_hit/rsp_way         : hit flag and hit (or written) way
//   rsp_victim              : replacement candidate, LOOKUP only
module tag_array_nway
  import tag_array_pkg::*;
#(
  parameter  int unsigned AWIDTH = 3,
  parameter  int unsigned TWIDTH = 16,
  parameter  int unsigned WAYS   = 2,
  localparam int unsigned WWIDTH = wwidth(WAYS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [TWIDTH-1:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WWIDTH-1:0] rsp_way,
  output logic [WWIDTH-1:0] rsp_victim
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned DWIDTH = TWIDTH + 1;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] sweep_q;
  op_e               op_q;
  logic [AWIDTH-1:0] idx_q;
  logic [TWIDTH-1:0] tag_q;
  logic [WWIDTH-1:0] ptr_q [DEPTH];

  logic [DWIDTH-1:0] rdata [WAYS];
  logic [WAYS-1:0]   we_c;
  logic [AWIDTH-1:0] addr_c;
  logic [DWIDTH-1:0] wdata_c;
  logic              accept_c;

  logic              hit_c, inv_found_c;
  logic [WWIDTH-1:0] hit_way_c, inv_way_c, victim_c, sel_way_c, ptr_nxt_c;
  logic [WWIDTH-1:0] way_c, vic_c;

  logic              hit_q;
  logic [WWIDTH-1:0] way_q, victim_q;

  assign accept_c = req_valid && req_ready && (state_q == ST_IDLE);

  // Per-way RAMs
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_way_ram #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_ram (
      .clock (clock),
      .we    (we_c[w]),
      .addr  (addr_c),
      .wdata (wdata_c),
      .rdata (rdata[w])
    );
  end

  // Parallel compare; descending scan leaves the lowest-numbered way selected.
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    inv_found_c = 1'b0;
    inv_way_c   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (rdata[w][TWIDTH] && (rdata[w][TWIDTH-1:0] == tag_q)) begin
        hit_c     = 1'b1;
        hit_way_c = WWIDTH'(w);
      end
      if (!rdata[w][TWIDTH]) begin
        inv_found_c = 1'b1;
        inv_way_c   = WWIDTH'(w);
      end
    end
    victim_c  = inv_found_c ? inv_way_c : ptr_q[idx_q];
    sel_way_c = (op_q == OP_FILL && !hit_c) ? victim_c : hit_way_c;
    ptr_nxt_c = (WAYS == 1) ? '0 : ptr_q[idx_q] + WWIDTH'(1);
    way_c     = sel_way_c;
    vic_c     = (op_q == OP_LOOKUP) ? victim_c : '0;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (sweep_q == AWIDTH'(DEPTH - 1)) state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept_c) begin
          case (op_e'(req_op))
            OP_LOOKUP: state_d = ST_RESP;
            OP_FLUSH:  state_d = ST_INIT;
            default:   state_d = ST_WRITE;
          endcase
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM control: sweep writes in INIT, fill/inval writes in WRITE.
  always_comb begin
    we_c    = '0;
    addr_c  = req_index;
    wdata_c = '0;
    case (state_q)
      ST_INIT: begin
        we_c   = '1;
        addr_c = sweep_q;
      end
      ST_WRITE: begin
        addr_c = idx_q;
        if (op_q == OP_FILL || hit_c) begin
          wdata_c = {(op_q == OP_FILL), tag_q};
          for (int w = 0; w < int'(WAYS); w++) we_c[w] = (WWIDTH'(w) == sel_way_c);
        end
      end
      default: ;
    endcase
  end

  // Handshake, command capture, sweep counter and response hold registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      sweep_q   <= '0;
      op_q      <= OP_LOOKUP;
      idx_q     <= '0;
      tag_q     <= '0;
      hit_q     <= 1'b0;
      way_q     <= '0;
      victim_q  <= '0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= accept_c && (op_e'(req_op) != OP_FLUSH);
      if (state_q == ST_INIT) sweep_q <= sweep_q + AWIDTH'(1);
      if (accept_c) begin
        op_q  <= op_e'(req_op);
        idx_q <= req_index;
        tag_q <= req_tag;
      end
      if (rsp_valid) begin
        hit_q    <= hit_c;
        way_q    <= way_c;
        victim_q <= vic_c;
      end
    end
  end

  // Round-robin pointers advance only when a fill evicts a valid line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ptr_q[i] <= '0;
    end else if (state_q == ST_INIT) begin
      ptr_q[sweep_q] <= '0;
    end else if (state_q == ST_WRITE && op_q == OP_FILL && !hit_c && !inv_found_c) begin
      ptr_q[idx_q] <= ptr_nxt_c;
    end
  end

  // Response fields come straight off the read port while valid, else hold.
  assign rsp_hit    = rsp_valid ? hit_c : hit_q;
  assign rsp_way    = rsp_valid ? way_c : way_q;
  assign rsp_victim = rsp_valid ? vic_c : victim_q;

endmodule

// File: tb/tb_tag_array_nway.sv
// Self-checking bench for tag_array_nway (AWIDTH=3, TWIDTH=8, WAYS=2).
module tb_tag_array_nway;

  localparam int AW = 3;
  localparam int TW = 8;
  localparam int NW = 2;
  localparam int ND = 8;

  localparam logic [1:0] LOOKUP = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] INVAL  = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [0:0]    rsp_way;
  logic [0:0]    rsp_victim;

  int total = 0;
  int bad   = 0;

  // Reference model: contents per set/way and a replacement pointer per set.
  bit            mv [ND][NW];
  logic [TW-1:0] mt [ND][NW];
  int            mr [ND];

  tag_array_nway #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(NW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_way    (rsp_way),
    .rsp_victim (rsp_victim)
  );

  always #5 clock = ~clock;

  function automatic void model_clear();
    for (int s = 0; s < ND; s++) begin
      mr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        mt[s][w] = '0;
      end
    end
  endfunction

  // Applies one command to the model and returns the expected response.
  function automatic void model_apply(input logic [1:0] op, input int s, input logic [TW-1:0] t,
                                      output bit eh, output int ew, output int ev);
    int hw = -1;
    int iw = -1;
    int vic;
    for (int w = NW - 1; w >= 0; w--) begin
      if (mv[s][w] && mt[s][w] == t) hw = w;
      if (!mv[s][w]) iw = w;
    end
    vic = (iw >= 0) ? iw : mr[s];
    eh  = (hw >= 0);
    ew  = eh ? hw : 0;
    ev  = 0;
    case (op)
      LOOKUP: ev = vic;
      FILL: begin
        if (!eh) begin
          ew = vic;
          if (iw < 0) mr[s] = (mr[s] + 1) % NW;
        end
        mv[s][ew] = 1'b1;
        mt[s][ew] = t;
      end
      INVAL: if (eh) mv[s][hw] = 1'b0;
      default: model_clear();
    endcase
  endfunction

  // Issues one command and samples the cycle after acceptance.
  task automatic send(input logic [1:0] op, input int s, input logic [TW-1:0] t,
                      output logic v, output logic h, output logic [0:0] w,
                      output logic [0:0] vic, output logic rdy);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL send_ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_index = AW'(s);
    req_tag   = t;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    v   = rsp_valid;
    h   = rsp_hit;
    w   = rsp_way;
    vic = rsp_victim;
    rdy = req_ready;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_index = '0;
    req_tag   = '0;
    model_clear();
    repeat (3) @(negedge clock);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
    total++; if (rsp_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", rsp_hit); end
    total++; if (rsp_way !== 1'b0) begin bad++; $display("FAIL reset_way: got %0b want 0", rsp_way); end
    total++; if (rsp_victim !== 1'b0) begin bad++; $display("FAIL reset_victim: got %0b want 0", rsp_victim); end
    reset_n = 1'b1;
    for (int i = 0; i < ND; i++) begin
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL init_ready_low cyc%0d: got %0b want 0", i, req_ready); end
      @(negedge clock);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL init_ready_rise: got %0b want 1", req_ready); end
    begin
      logic v, h, rdy;
      logic [0:0] w, vic;
      bit eh; int ew, ev;
      model_apply(LOOKUP, 0, 8'h00, eh, ew, ev);
      send(LOOKUP, 0, 8'h00, v, h, w, vic, rdy);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL reset_lookup_valid: got %0b want 1", v); end
      total++; if (h !== 1'b0) begin bad++; $display("FAIL reset_lookup_hit: got %0b want 0", h); end
      total++; if (vic !== 1'b0) begin bad++; $display("FAIL reset_lookup_victim: got %0b want 0", vic); end
    end
  endtask

  // Directed sequence on set 3 with hand-derived expectations.
  task automatic test_directed();
    logic [1:0] ops  [16] = '{FILL, FILL, LOOKUP, LOOKUP, LOOKUP, FILL, LOOKUP, FILL,
                              INVAL, LOOKUP, FILL, FILL, LOOKUP, LOOKUP, LOOKUP, LOOKUP};
    logic [7:0] tags [16] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'h33, 8'h33, 8'hA5, 8'h44,
                              8'h44, 8'h44, 8'h77, 8'h77, 8'h99, 8'h33, 8'h77, 8'h5A};
    bit         ehs  [16] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0};
    int         ews  [16] = '{0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0};
    int         evs  [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      logic v, h, rdy;
      logic [0:0] w, vic;
      bit eh; int ew, ev;
      model_apply(ops[i], 3, tags[i], eh, ew, ev);
      send(ops[i], 3, tags[i], v, h, w, vic, rdy);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL dir%0d_valid: got %0b want 1", i, v); end
      total++; if (h !== ehs[i]) begin bad++; $display("FAIL dir%0d_hit: got %0b want %0b", i, h, ehs[i]); end
      total++; if (w !== 1'(ews[i])) begin bad++; $display("FAIL dir%0d_way: got %0d want %0d", i, w, ews[i]); end
      total++; if (vic !== 1'(evs[i])) begin bad++; $display("FAIL dir%0d_victim: got %0d want %0d", i, vic, evs[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic v, h, rdy;
    logic [0:0] w, vic;
    bit eh; int ew, ev;
    model_apply(LOOKUP, 3, 8'h77, eh, ew, ev);
    send(LOOKUP, 3, 8'h77, v, h, w, vic, rdy);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy: got %0b want 0", rdy); end
    @(negedge clock);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back: got %0b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %0b want 0", rsp_valid); end
    total++; if (rsp_hit !== eh || rsp_way !== 1'(ew)) begin
      bad++; $display("FAIL b2b_hold: got hit=%0b way=%0d want hit=%0b way=%0d", rsp_hit, rsp_way, eh, ew);
    end
    model_apply(FILL, 6, 8'h21, eh, ew, ev);
    send(FILL, 6, 8'h21, v, h, w, vic, rdy);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL b2b_fill_ready: got %0b want 0", rdy); end
    model_apply(LOOKUP, 6, 8'h21, eh, ew, ev);
    send(LOOKUP, 6, 8'h21, v, h, w, vic, rdy);
    total++; if (h !== 1'b1 || w !== 1'(ew)) begin
      bad++; $display("FAIL b2b_fill_visible: got hit=%0b way=%0d want hit=1 way=%0d", h, w, ew);
    end
  endtask

  task automatic test_flush();
    logic v, h, rdy;
    logic [0:0] w, vic;
    bit eh; int ew, ev;
    for (int s = 0; s < ND; s++) begin
      model_apply(FILL, s, 8'(8'h10 + s), eh, ew, ev);
      send(FILL, s, 8'(8'h10 + s), v, h, w, vic, rdy);
      total++; if (h !== eh || w !== 1'(ew)) begin
        bad++; $display("FAIL flush_fill%0d: got hit=%0b way=%0d want hit=%0b way=%0d", s, h, w, eh, ew);
      end
    end
    model_apply(FLUSH, 0, 8'h00, eh, ew, ev);
    send(FLUSH, 0, 8'h00, v, h, w, vic, rdy);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL flush_no_rsp: got %0b want 0", v); end
    for (int i = 0; i < ND; i++) begin
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready_low cyc%0d: got %0b want 0", i, req_ready); end
      @(negedge clock);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_rise: got %0b want 1", req_ready); end
    for (int s = 0; s < ND; s++) begin
      model_apply(LOOKUP, s, 8'(8'h10 + s), eh, ew, ev);
      send(LOOKUP, s, 8'(8'h10 + s), v, h, w, vic, rdy);
      total++; if (h !== 1'b0 || vic !== 1'b0) begin
        bad++; $display("FAIL flush_lookup%0d: got hit=%0b victim=%0d want hit=0 victim=0", s, h, vic);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [4] = '{8'h0C, 8'h3E, 8'hC1, 8'h6B};
    for (int i = 0; i < 300; i++) begin
      logic v, h, rdy;
      logic [0:0] w, vic;
      bit eh; int ew, ev;
      logic [1:0] op = 2'($urandom_range(0, 2));
      int s = int'($urandom_range(0, 3));
      logic [7:0] t = pool[$urandom_range(0, 3)];
      model_apply(op, s, t, eh, ew, ev);
      send(op, s, t, v, h, w, vic, rdy);
      total++;
      if (v !== 1'b1 || h !== eh || w !== 1'(ew) || vic !== 1'(ev)) begin
        bad++;
        $display("FAIL rnd%0d op%0d set%0d tag%02h: got v=%0b h=%0b w=%0d vic=%0d want v=1 h=%0b w=%0d vic=%0d",
                 i, op, s, t, v, h, w, vic, eh, ew, ev);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic v, h, rdy;
    logic [0:0] w, vic;
    bit eh; int ew, ev;
    @(negedge clock);
    while (!req_ready) @(negedge clock);
    req_valid = 1'b1;
    req_op    = FILL;
    req_index = 3'd5;
    req_tag   = 8'hC3;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", rsp_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %0b want 0", req_ready); end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < ND; i++) begin
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_init cyc%0d: got %0b want 0", i, req_ready); end
      @(negedge clock);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_rise: got %0b want 1", req_ready); end
    model_apply(LOOKUP, 5, 8'hC3, eh, ew, ev);
    send(LOOKUP, 5, 8'hC3, v, h, w, vic, rdy);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL midrst_lookup: got hit=%0b want 0", h); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
